// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier (NB x NB -> 2*NB) with start/ready/busy handshake.
// Optional ZERO_SKIP_EN: a zero operand finishes one cycle after accept with Product=0.
module booth_r4_multiplier #(
    parameter int NB = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NB-1:0]   A,
    input  logic [NB-1:0]   B,
    input  logic            signed_mode,
    output logic [2*NB-1:0] Product,
    output logic            ready,
    output logic            busy
);

    localparam int W    = (NB % 2 == 0) ? NB + 2 : NB + 1;
    localparam int ITER = W / 2;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_ext;
    logic [W:0]      b_sh;
    logic [2*W-1:0]  acc;
    logic [CW-1:0]   k;
    logic [2*W-1:0]  a_wide;
    logic [2*W-1:0]  pp;
    logic [2*W-1:0]  addend;
    logic [2*W-1:0]  acc_next;
    logic            a_sign;
    logic            b_sign;

    assign a_sign = signed_mode & A[NB-1];
    assign b_sign = signed_mode & B[NB-1];

    // b_sh carries B with an appended zero (B[-1]); its low three bits are the current triplet.
    always_comb begin
        a_wide = {{W{a_ext[W-1]}}, a_ext};
        pp     = '0;
        case (b_sh[2:0])
            3'b001, 3'b010: pp = a_wide;
            3'b011:         pp = a_wide << 1;
            3'b100:         pp = -(a_wide << 1);
            3'b101, 3'b110: pp = -a_wide;
            default:        pp = '0;
        endcase
        addend   = pp << {k, 1'b0};
        acc_next = acc + addend;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            Product <= '0;
            ready   <= 1'b0;
            busy    <= 1'b0;
            k       <= '0;
            acc     <= '0;
            a_ext   <= '0;
            b_sh    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_ext <= {{(W-NB){a_sign}}, A};
                        b_sh  <= {{(W-NB){b_sign}}, B, 1'b0};
                        acc   <= '0;
                        k     <= '0;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
`ifdef ZERO_SKIP_EN
                    // Only the first RUN edge sees unshifted B, so the zero test is gated on k==0.
                    if (k == '0 && (a_ext == '0 || b_sh == '0)) begin
                        Product <= '0;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end else
`endif
                    begin
                        acc  <= acc_next;
                        b_sh <= b_sh >> 2;
                        if (k == CW'(ITER - 1)) begin
                            Product <= acc_next[2*NB-1:0];
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
